// File: rtl/scene_ctrl_pkg.sv
// rtl/scene_ctrl_pkg.sv - shared ray-tracer types: controller state encoding and triangle word count
package scene_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // A triangle is normal + three vertices, three coordinates each.
  localparam int TRI_WORDS = 12;
endpackage

// File: rtl/scene_ctrl_if.sv
// rtl/scene_ctrl_if.sv - scene load, ray push and status bundle between host side and scene_ctrl
interface scene_ctrl_if #(
  parameter int D_BITS   = 32,
  parameter int M_BITS   = 12,
  parameter int CNT_BITS = 16
);
  import scene_ctrl_pkg::*;

  logic                          load_start;
  logic                          tri_valid;
  logic                          tri_last;
  logic [TRI_WORDS*D_BITS-1:0]   tri_data;
  logic                          tri_ready;
  logic                          mem_wr_en;
  logic [M_BITS-1:0]             mem_wr_addr;
  logic [TRI_WORDS*D_BITS-1:0]   mem_din;
  logic [M_BITS:0]               num_tris;
  logic                          ray_wr_req;
  logic                          ray_fifo_full;
  logic                          ray_wr_en;
  logic                          ray_ready;
  logic                          result_wr;
  logic [CNT_BITS-1:0]           in_flight;
  logic [1:0]                    state_out;
  logic                          busy;
  logic                          err;

  modport master (
    output load_start, tri_valid, tri_last, tri_data, ray_wr_req, ray_fifo_full, result_wr,
    input  tri_ready, mem_wr_en, mem_wr_addr, mem_din, num_tris, ray_wr_en, ray_ready,
           in_flight, state_out, busy, err
  );

  modport slave (
    input  load_start, tri_valid, tri_last, tri_data, ray_wr_req, ray_fifo_full, result_wr,
    output tri_ready, mem_wr_en, mem_wr_addr, mem_din, num_tris, ray_wr_en, ray_ready,
           in_flight, state_out, busy, err
  );
endinterface

// File: rtl/sat_updown_cnt.sv
// rtl/sat_updown_cnt.sv - up/down counter that never wraps; flags a decrement attempted at zero
module sat_updown_cnt #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         resetn_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         at_max_o,
  output logic         underflow_o
);
  logic [W-1:0] cnt_q, cnt_d;

  assign count_o     = cnt_q;
  assign at_max_o    = &cnt_q;
  assign underflow_o = dec_i && !inc_i && (cnt_q == '0);

  // Simultaneous inc and dec cancel; a lone step past either end is dropped.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && !at_max_o) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/scene_ctrl.sv
// rtl/scene_ctrl.sv - scene loader into triangle memory and in-flight ray admission control
module scene_ctrl
  import scene_ctrl_pkg::*;
#(
  parameter int D_BITS   = 32,
  parameter int M_BITS   = 12,
  parameter int CNT_BITS = 16
) (
  input logic         clock,
  input logic         reset,
  scene_ctrl_if.slave bus
);
  state_e                        state_q;
  logic [M_BITS:0]               cnt_q;
  logic                          mem_wr_en_q;
  logic [M_BITS-1:0]             mem_wr_addr_q;
  logic [TRI_WORDS*D_BITS-1:0]   mem_din_q;
  logic                          err_q;

  logic                          tri_ready;
  logic                          tri_acc;
  logic                          last_slot;
  logic                          ray_ready;
  logic                          ray_wr_en;
  logic [CNT_BITS-1:0]           in_flight;
  logic                          fl_at_max;
  logic                          fl_underflow;

  // cnt_q never exceeds CAP, so its top bit alone means "memory full".
  assign tri_ready = (state_q == ST_LOAD) && !cnt_q[M_BITS];
  assign tri_acc   = bus.tri_valid && tri_ready;
  assign last_slot = &cnt_q[M_BITS-1:0];
  assign ray_ready = (state_q == ST_RUN) && !bus.ray_fifo_full && !fl_at_max;
  assign ray_wr_en = bus.ray_wr_req && ray_ready;

  sat_updown_cnt #(.W(CNT_BITS)) u_in_flight (
    .clk_i       (clock),
    .resetn_i    (reset),
    .inc_i       (ray_wr_en),
    .dec_i       (bus.result_wr),
    .count_o     (in_flight),
    .at_max_o    (fl_at_max),
    .underflow_o (fl_underflow)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      mem_wr_en_q   <= 1'b0;
      mem_wr_addr_q <= '0;
      mem_din_q     <= '0;
      err_q         <= 1'b0;
    end else begin
      mem_wr_en_q <= tri_acc;
      if (fl_underflow) begin
        err_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (bus.load_start) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
          end
        end
        ST_LOAD: begin
          if (tri_acc) begin
            cnt_q         <= cnt_q + {{M_BITS{1'b0}}, 1'b1};
            mem_wr_addr_q <= cnt_q[M_BITS-1:0];
            mem_din_q     <= bus.tri_data;
            if (bus.tri_last || last_slot) begin
              state_q <= ST_RUN;
            end
            // Filling memory without seeing the final triangle truncates the scene.
            if (!bus.tri_last && last_slot) begin
              err_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (bus.load_start) begin
            if (in_flight == '0) begin
              state_q <= ST_LOAD;
              cnt_q   <= '0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.tri_ready   = tri_ready;
  assign bus.mem_wr_en   = mem_wr_en_q;
  assign bus.mem_wr_addr = mem_wr_addr_q;
  assign bus.mem_din     = mem_din_q;
  assign bus.num_tris    = cnt_q;
  assign bus.ray_ready   = ray_ready;
  assign bus.ray_wr_en   = ray_wr_en;
  assign bus.in_flight   = in_flight;
  assign bus.state_out   = state_q;
  assign bus.busy        = (state_q == ST_LOAD) || ((state_q == ST_RUN) && (in_flight != '0));
  assign bus.err         = err_q;
endmodule

// File: tb/tb_scene_ctrl.sv
// tb/tb_scene_ctrl.sv - scene_ctrl bench: directed scenarios plus random traffic against a reference model
module tb_scene_ctrl;
  import scene_ctrl_pkg::*;

  localparam int D_BITS   = 8;
  localparam int M_BITS   = 3;
  localparam int CNT_BITS = 3;
  localparam int CAP      = 1 << M_BITS;
  localparam int FMAX     = (1 << CNT_BITS) - 1;
  localparam int TW       = TRI_WORDS * D_BITS;

  logic clock = 1'b0;
  logic reset = 1'b0;

  scene_ctrl_if #(.D_BITS(D_BITS), .M_BITS(M_BITS), .CNT_BITS(CNT_BITS)) bus ();

  scene_ctrl #(.D_BITS(D_BITS), .M_BITS(M_BITS), .CNT_BITS(CNT_BITS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic ck(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference model: scene state, triangle count, ray occupancy, sticky error, pending write.
  int                m_st = 0;
  int                m_n = 0;
  int                m_fl = 0;
  bit                m_err = 0;
  bit                m_wen = 0;
  bit                m_live = 0;
  bit                m_rst_prev = 0;
  int                m_addr = 0;
  logic [TW-1:0]     m_din = '0;

  always @(negedge clock) begin
    bit tr, rr, acc, push;
    tr = (m_st == 1) && (m_n < CAP);
    rr = (m_st == 2) && !bus.ray_fifo_full && (m_fl < FMAX);
    if (m_live) begin
      ck("state_out", 128'(bus.state_out), 128'(m_st));
      ck("num_tris", 128'(bus.num_tris), 128'(m_n));
      ck("in_flight", 128'(bus.in_flight), 128'(m_fl));
      ck("err", 128'(bus.err), 128'(m_err));
      ck("busy", 128'(bus.busy), 128'((m_st == 1) || (m_st == 2 && m_fl != 0)));
      ck("mem_wr_en", 128'(bus.mem_wr_en), 128'(m_wen));
      if (m_wen || m_rst_prev) begin
        ck("mem_wr_addr", 128'(bus.mem_wr_addr), 128'(m_addr));
        ck("mem_din", 128'(bus.mem_din), 128'(m_din));
      end
      ck("tri_ready", 128'(bus.tri_ready), 128'(tr));
      ck("ray_ready", 128'(bus.ray_ready), 128'(rr));
      ck("ray_wr_en", 128'(bus.ray_wr_en), 128'(bus.ray_wr_req && rr));
    end
    if (!reset) begin
      m_st = 0; m_n = 0; m_fl = 0; m_err = 0;
      m_wen = 0; m_addr = 0; m_din = '0;
      m_rst_prev = 1; m_live = 1;
    end else begin
      m_rst_prev = 0;
      acc  = bus.tri_valid && tr;
      push = bus.ray_wr_req && rr;
      m_wen = acc;
      if (acc) begin
        m_addr = m_n;
        m_din  = bus.tri_data;
      end
      case (m_st)
        0: if (bus.load_start) begin m_st = 1; m_n = 0; end
        1: if (acc) begin
             m_n++;
             if (bus.tri_last) m_st = 2;
             else if (m_n == CAP) begin m_st = 2; m_err = 1; end
           end
        default: if (bus.load_start) begin
             if (m_fl == 0) begin m_st = 1; m_n = 0; end
             else m_err = 1;
           end
      endcase
      if (push && !bus.result_wr) m_fl++;
      else if (bus.result_wr && !push) begin
        if (m_fl == 0) m_err = 1;
        else m_fl--;
      end
    end
  end

  initial begin
    logic [TW-1:0] tri_a, tri_b, tri_c;
    int pulses;
    tri_a = {TRI_WORDS{8'hA5}};
    tri_b = {TRI_WORDS{8'hB6}};
    tri_c = {TRI_WORDS{8'hC7}};
    bus.load_start = 0; bus.tri_valid = 0; bus.tri_last = 0; bus.tri_data = '0;
    bus.ray_wr_req = 0; bus.ray_fifo_full = 0; bus.result_wr = 0;

    reset = 0; tick(); tick();
    ck("rst state", 128'(bus.state_out), 128'(0));
    ck("rst num_tris", 128'(bus.num_tris), 128'(0));
    ck("rst in_flight", 128'(bus.in_flight), 128'(0));
    ck("rst err", 128'(bus.err), 128'(0));
    ck("rst mem_wr_en", 128'(bus.mem_wr_en), 128'(0));
    ck("rst busy", 128'(bus.busy), 128'(0));
    reset = 1;

    // Three-triangle scene
    bus.load_start = 1; tick(); bus.load_start = 0;
    ck("load state", 128'(bus.state_out), 128'(1));
    bus.tri_valid = 1; bus.tri_data = tri_a; tick();
    ck("wr0 en", 128'(bus.mem_wr_en), 128'(1));
    ck("wr0 addr", 128'(bus.mem_wr_addr), 128'(0));
    ck("wr0 data", 128'(bus.mem_din), 128'(tri_a));
    bus.tri_data = tri_b; tick();
    ck("wr1 addr", 128'(bus.mem_wr_addr), 128'(1));
    ck("wr1 data", 128'(bus.mem_din), 128'(tri_b));
    bus.tri_data = tri_c; bus.tri_last = 1; tick();
    ck("wr2 addr", 128'(bus.mem_wr_addr), 128'(2));
    ck("wr2 data", 128'(bus.mem_din), 128'(tri_c));
    ck("num_tris 3", 128'(bus.num_tris), 128'(3));
    ck("run after last", 128'(bus.state_out), 128'(2));
    bus.tri_valid = 0; bus.tri_last = 0; bus.tri_data = '0;
    tick();
    ck("no wr after load", 128'(bus.mem_wr_en), 128'(0));

    // Five push requests, FIFO full on the 2nd and 3rd
    pulses = 0;
    for (int i = 1; i <= 5; i++) begin
      bus.ray_wr_req = 1; bus.ray_fifo_full = (i == 2 || i == 3);
      #1;
      if (bus.ray_wr_en) pulses++;
      tick();
    end
    bus.ray_wr_req = 0; bus.ray_fifo_full = 0;
    ck("push pulses", 128'(pulses), 128'(3));
    ck("in_flight 3", 128'(bus.in_flight), 128'(3));

    // Push and result together, then drain
    bus.ray_wr_req = 1; bus.result_wr = 1; #1;
    ck("push with result", 128'(bus.ray_wr_en), 128'(1));
    tick();
    ck("in_flight hold 3", 128'(bus.in_flight), 128'(3));
    bus.ray_wr_req = 0;
    repeat (3) tick();
    bus.result_wr = 0;
    ck("drained", 128'(bus.in_flight), 128'(0));
    ck("idle busy", 128'(bus.busy), 128'(0));
    ck("no err yet", 128'(bus.err), 128'(0));

    // Reload refused with rays outstanding
    bus.ray_wr_req = 1; tick(); tick(); bus.ray_wr_req = 0;
    ck("in_flight 2", 128'(bus.in_flight), 128'(2));
    bus.load_start = 1; tick(); bus.load_start = 0;
    ck("reload refused", 128'(bus.state_out), 128'(2));
    ck("reload err", 128'(bus.err), 128'(1));
    bus.result_wr = 1; tick(); tick(); bus.result_wr = 0;
    bus.load_start = 1; tick(); bus.load_start = 0;
    ck("reload ok", 128'(bus.state_out), 128'(1));
    ck("reload num_tris", 128'(bus.num_tris), 128'(0));

    // Reset in the middle of a load
    bus.tri_valid = 1; bus.tri_data = tri_a; tick();
    bus.tri_data = tri_b; tick();
    ck("partial num_tris", 128'(bus.num_tris), 128'(2));
    bus.tri_data = tri_c; reset = 0; tick();
    ck("midload rst state", 128'(bus.state_out), 128'(0));
    ck("midload rst num", 128'(bus.num_tris), 128'(0));
    ck("midload rst wr_en", 128'(bus.mem_wr_en), 128'(0));
    ck("midload rst err", 128'(bus.err), 128'(0));
    reset = 1; bus.tri_valid = 0; tick();
    ck("no stale write", 128'(bus.mem_wr_en), 128'(0));

    // Result while idle and empty
    bus.result_wr = 1; tick(); bus.result_wr = 0;
    ck("underflow count", 128'(bus.in_flight), 128'(0));
    ck("underflow err", 128'(bus.err), 128'(1));

    // Fill memory to capacity without a final marker, then saturate in_flight
    reset = 0; tick(); reset = 1;
    bus.load_start = 1; tick(); bus.load_start = 0;
    bus.tri_valid = 1;
    for (int i = 0; i < CAP; i++) begin
      bus.tri_data = {$urandom(), $urandom(), $urandom()};
      tick();
    end
    bus.tri_valid = 0;
    ck("cap state", 128'(bus.state_out), 128'(2));
    ck("cap num_tris", 128'(bus.num_tris), 128'(CAP));
    ck("cap err", 128'(bus.err), 128'(1));
    bus.ray_wr_req = 1;
    repeat (FMAX + 2) tick();
    bus.ray_wr_req = 0; #1;
    ck("sat in_flight", 128'(bus.in_flight), 128'(FMAX));
    ck("sat ray_ready", 128'(bus.ray_ready), 128'(0));

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      reset            = ($urandom_range(199) != 0);
      bus.load_start   = ($urandom_range(15) == 0);
      bus.tri_valid    = $urandom_range(1);
      bus.tri_last     = ($urandom_range(5) == 0);
      bus.tri_data     = {$urandom(), $urandom(), $urandom()};
      bus.ray_wr_req   = $urandom_range(1);
      bus.ray_fifo_full = ($urandom_range(3) == 0);
      bus.result_wr    = ($urandom_range(2) == 0);
      tick();
    end
    bus.load_start = 0; bus.tri_valid = 0; bus.ray_wr_req = 0; bus.result_wr = 0;
    reset = 1;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/scene_ctrl.md
SCENE_CTRL -- requirements
Module: scene_ctrl

Interface
REQ-001 SHALL have parameter D_BITS, default 32, fixed-point word width.
REQ-002 SHALL have parameter M_BITS, default 12, triangle memory address width; capacity CAP = 2**M_BITS.
REQ-003 SHALL have parameter CNT_BITS, default 16, width of the in-flight ray counter.
REQ-004 SHALL have ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-low reset.
- load_start  in  1  one-cycle request to begin a scene load.
- tri_valid  in  1  triangle word valid.
- tri_last  in  1  marks the final triangle; qualified by tri_valid.
- tri_data  in  12*D_BITS  packed triangle (normal, v0, v1, v2).
- tri_ready  out  1  triangle accept.
- mem_wr_en  out  1  triangle memory write strobe.
- mem_wr_addr  out  M_BITS  write address.
- mem_din  out  12*D_BITS  write data.
- num_tris  out  M_BITS+1  triangle count of the loaded scene.
- ray_wr_req  in  1  upstream ray push request.
- ray_fifo_full  in  1  input ray FIFO full.
- ray_wr_en  out  1  gated push into the input ray FIFO.
- ray_ready  out  1  ray push will be accepted this cycle.
- result_wr  in  1  one ray finished (accumulator write strobe).
- in_flight  out  CNT_BITS  rays accepted but not finished.
- state_out  out  2  current state encoding.
- busy  out  1  high in LOAD, or in RUN with in_flight != 0.
- err  out  1  sticky protocol-error flag.

Function
REQ-005 SHALL implement states IDLE=0, LOAD=1, RUN=2.
REQ-006 SHALL move IDLE->LOAD on load_start; in LOAD, num_tris and the write pointer SHALL be zeroed on the entry cycle.
REQ-007 SHALL move RUN->LOAD on load_start only when in_flight == 0; otherwise SHALL stay in RUN, ignore the request and set err.
REQ-008 SHALL assert tri_ready only in LOAD with write pointer < CAP.
REQ-009 SHALL accept a triangle when tri_valid && tri_ready; the accept is the handshake, and tri_data is not held afterwards.
REQ-010 SHALL drive mem_wr_en, mem_wr_addr and mem_din one cycle after acceptance (registered), with mem_wr_addr equal to the pointer at acceptance; the pointer and num_tris SHALL increment by 1 per accept.
REQ-011 SHALL move LOAD->RUN in the cycle after accepting a triangle with tri_last=1, or after accepting the CAP-th triangle; CAP without tri_last SHALL set err.
REQ-012 SHALL ignore load_start while in LOAD.
REQ-013 SHALL assert ray_ready = (state==RUN) && !ray_fifo_full, and ray_wr_en = ray_wr_req && ray_ready (combinational, zero latency).
REQ-014 SHALL update in_flight: +1 on ray_wr_en alone, -1 on result_wr alone, unchanged on both together.
REQ-015 SHALL saturate in_flight: result_wr at 0 leaves it 0 and sets err; a push at the maximum value SHALL be blocked by forcing ray_ready low.
REQ-016 SHALL count result_wr in every state.
REQ-017 SHALL hold num_tris constant throughout RUN.
REQ-018 SHALL clear err only by reset.

Reset
REQ-019 SHALL, when reset==0 at a clock edge:
- set state to IDLE.
- set num_tris, the write pointer, in_flight and err to 0.
- set mem_wr_en to 0; mem_wr_addr and mem_din to 0.
REQ-020 SHALL make reset mid-LOAD discard the partial scene; an accepted write already registered SHALL not be issued.
REQ-021 SHALL drive all outputs to their reset values in the cycle following the reset edge.

Structure
REQ-022 SHALL take the state enum and the 12-word triangle width constant from the shared ray-tracer package.
REQ-023 SHALL be a single module with no sub-modules; the in_flight up/down saturating counter MAY be a separate sub-module, sat_updown_cnt.

Verification
REQ-024 Load 3 triangles (last on third), data 0xA.., 0xB.., 0xC.. -> mem writes at addr 0,1,2 one cycle after each accept; num_tris=3; state RUN the cycle after the third accept.
REQ-025 In RUN, ray_wr_req high 5 cycles with ray_fifo_full high in cycles 2-3 -> 3 ray_wr_en pulses; in_flight=3.
REQ-026 in_flight=3, ray_wr_en and result_wr in the same cycle -> in_flight stays 3; then 3 result_wr pulses -> in_flight=0, busy=0.
REQ-027 load_start with in_flight=2 -> state stays RUN, err=1; after both results, load_start -> LOAD, num_tris=0.
REQ-028 result_wr in IDLE with in_flight=0 -> in_flight stays 0, err=1.
REQ-029 Reset low mid-LOAD after 2 accepts -> next cycle state IDLE, num_tris=0, mem_wr_en=0, no pending write issued.
